// File: rtl/mem_rsp_slave.sv
// mem_rsp_slave: memory-side responder for the arbiter's downstream port.
// Requests are queued in order and serviced after a programmable latency
// against an internal storage array. Reads return data and tag on the
// response port, and writes are committed silently.
module mem_rsp_slave #(
  parameter int W    = 16,
  parameter int AW   = 10,
  parameter int TW   = 4,
  parameter int QAW  = 2,
  parameter int LATW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LATW-1:0] lat,
  input  logic            mem_req,
  input  logic [AW-1:0]   mem_addr,
  input  logic            mem_read,
  input  logic [W-1:0]    mem_wdata,
  input  logic [TW-1:0]   mem_tag,
  output logic            mem_bsy,
  output logic            rsp_vld,
  output logic [W-1:0]    rsp_rdata,
  output logic [TW-1:0]   rsp_tag,
  input  logic            rsp_bsy,
  output logic [15:0]     wr_cnt,
  output logic [15:0]     rd_cnt
);

  localparam int QD = 2 ** QAW;

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  state_t          state, state_nxt;
  logic [LATW-1:0] timer, timer_nxt;
  logic [LATW-1:0] lat_load;

  logic [AW-1:0]   q_addr  [QD];
  logic            q_read  [QD];
  logic [W-1:0]    q_wdata [QD];
  logic [TW-1:0]   q_tag   [QD];
  logic [QAW-1:0]  wr_ptr, rd_ptr;
  logic [QAW:0]    count;

  logic [W-1:0]    mem [2**AW];

  logic            push, pop, wr_commit, rd_issue, remain;
  logic [AW-1:0]   head_addr;
  logic            head_read;
  logic [W-1:0]    head_wdata;
  logic [TW-1:0]   head_tag;

  assign mem_bsy    = (count == (QAW+1)'(QD));
  assign push       = mem_req & ~mem_bsy;
  assign lat_load   = (lat == '0) ? '0 : lat - LATW'(1);
  assign head_addr  = q_addr[rd_ptr];
  assign head_read  = q_read[rd_ptr];
  assign head_wdata = q_wdata[rd_ptr];
  assign head_tag   = q_tag[rd_ptr];
  // Entries left after this cycle's pop, counting a same-cycle push.
  assign remain     = (count != (QAW+1)'(1)) | push;

  // State and latency timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Next-state, latency countdown and service decisions.
  // IDLE reacts to the push itself, so a lat<=1 request reaches ISSUE on
  // the cycle right after acceptance; later entries always pass through WAIT.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pop       = 1'b0;
    wr_commit = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (push) begin
          if (lat_load == '0) begin
            state_nxt = ISSUE;
          end else begin
            state_nxt = WAIT;
            timer_nxt = lat_load;
          end
        end
      end
      WAIT: begin
        if (timer == '0) state_nxt = ISSUE;
        else             timer_nxt = timer - LATW'(1);
      end
      ISSUE: begin
        if (head_read) begin
          if (!rsp_bsy) begin
            pop      = 1'b1;
            rd_issue = 1'b1;
          end
        end else begin
          pop       = 1'b1;
          wr_commit = 1'b1;
        end
        if (pop) begin
          if (remain) begin
            state_nxt = WAIT;
            timer_nxt = lat_load;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QAW'(1);
      if (pop)  rd_ptr <= rd_ptr + QAW'(1);
      case ({push, pop})
        2'b10:   count <= count + (QAW+1)'(1);
        2'b01:   count <= count - (QAW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue entry storage (not reset; validity follows the pointers).
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= mem_addr;
      q_read[wr_ptr]  <= mem_read;
      q_wdata[wr_ptr] <= mem_wdata;
      q_tag[wr_ptr]   <= mem_tag;
    end
  end

  // Storage array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[head_addr] <= head_wdata;
  end

  // Response register and activity counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld   <= 1'b0;
      rsp_rdata <= '0;
      rsp_tag   <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      rsp_vld <= rd_issue;
      if (rd_issue) begin
        rsp_rdata <= mem[head_addr];
        rsp_tag   <= head_tag;
        rd_cnt    <= rd_cnt + 16'd1;
      end
      if (wr_commit) wr_cnt <= wr_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_rsp_slave.sv
// tb_mem_rsp_slave: directed scenarios plus randomized traffic checked
// against an in-order reference model (model memory updated at accept time).
module tb_mem_rsp_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  lat = 3'd1;
  logic        mem_req = 1'b0;
  logic [9:0]  mem_addr = '0;
  logic        mem_read = 1'b0;
  logic [15:0] mem_wdata = '0;
  logic [3:0]  mem_tag = '0;
  logic        mem_bsy;
  logic        rsp_vld;
  logic [15:0] rsp_rdata;
  logic [3:0]  rsp_tag;
  logic        rsp_bsy = 1'b0;
  logic [15:0] wr_cnt, rd_cnt;

  typedef struct { logic [3:0] tag; logic [15:0] data; int cyc; } rsp_t;
  typedef struct { logic [3:0] tag; logic [15:0] data; } exp_t;

  rsp_t        got_q[$];
  exp_t        exp_q[$];
  rsp_t        mon_r;
  logic [15:0] mem_m [1024];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit bsy_mode = 1'b0;

  mem_rsp_slave #(.W(16), .AW(10), .TW(4), .QAW(2), .LATW(3)) dut (
    .clk(clk), .rst_n(rst_n), .lat(lat),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_wdata(mem_wdata), .mem_tag(mem_tag), .mem_bsy(mem_bsy),
    .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
    .rsp_bsy(rsp_bsy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every response with the cycle it was seen in.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_vld === 1'b1) begin
      mon_r.tag  = rsp_tag;
      mon_r.data = rsp_rdata;
      mon_r.cyc  = cyc;
      got_q.push_back(mon_r);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bsy_mode) rsp_bsy = 1'($urandom_range(0, 1));
  endtask

  // Present one request until accepted; updates the reference model.
  task automatic push(input logic [9:0] a, input logic rd, input logic [15:0] d,
                      input logic [3:0] t, output int tcyc);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    tcyc = -1;
    mem_req = 1'b1; mem_addr = a; mem_read = rd; mem_wdata = d; mem_tag = t;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (mem_bsy === 1'b0) begin
        ok = 1'b1;
        tcyc = cyc;
      end
      step();
    end
    mem_req = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL push_accept: got no accept, expected accept within 300 cycles");
    end else if (rd) begin
      e.tag = t; e.data = mem_m[a];
      exp_q.push_back(e);
    end else begin
      mem_m[a] = d;
    end
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 2000 && got_q.size() < n; k++) step();
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    @(negedge clk);
    n_cmp++; if (mem_bsy !== 1'b0)    begin n_err++; $display("FAIL reset_mem_bsy: got %b expected 0", mem_bsy); end
    n_cmp++; if (rsp_vld !== 1'b0)    begin n_err++; $display("FAIL reset_rsp_vld: got %b expected 0", rsp_vld); end
    n_cmp++; if (rsp_rdata !== 16'h0) begin n_err++; $display("FAIL reset_rsp_rdata: got %h expected 0000", rsp_rdata); end
    n_cmp++; if (rsp_tag !== 4'h0)    begin n_err++; $display("FAIL reset_rsp_tag: got %h expected 0", rsp_tag); end
    n_cmp++; if (wr_cnt !== 16'h0)    begin n_err++; $display("FAIL reset_wr_cnt: got %0d expected 0", wr_cnt); end
    n_cmp++; if (rd_cnt !== 16'h0)    begin n_err++; $display("FAIL reset_rd_cnt: got %0d expected 0", rd_cnt); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    int t0, t1;
    got_q.delete(); exp_q.delete();
    lat = 3'd1;
    push(10'h005, 1'b0, 16'h00A5, 4'd1, t0);
    push(10'h005, 1'b1, 16'h0000, 4'd2, t1);
    wait_rsp(1);
    n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL wr_rd_count: got %0d responses expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0].data !== 16'h00A5) begin n_err++; $display("FAIL wr_rd_data: got %h expected 00a5", got_q[0].data); end
      n_cmp++; if (got_q[0].tag !== 4'd2) begin n_err++; $display("FAIL wr_rd_tag: got %0d expected 2", got_q[0].tag); end
    end
    @(negedge clk);
    n_cmp++; if (wr_cnt !== 16'd1) begin n_err++; $display("FAIL wr_rd_wr_cnt: got %0d expected 1", wr_cnt); end
    n_cmp++; if (rd_cnt !== 16'd1) begin n_err++; $display("FAIL wr_rd_rd_cnt: got %0d expected 1", rd_cnt); end
    step();
  endtask

  // Single read from an empty queue: response cycle relative to accept.
  task automatic test_latency(input logic [2:0] l, input int off);
    int t;
    got_q.delete(); exp_q.delete();
    lat = l;
    push(10'h005, 1'b1, 16'h0000, 4'd3, t);
    wait_rsp(1);
    n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL lat%0d_count: got %0d responses expected 1", l, got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0].cyc != t + off) begin n_err++; $display("FAIL lat%0d_cycle: got T+%0d expected T+%0d", l, got_q[0].cyc - t, off); end
      n_cmp++; if (got_q[0].data !== 16'h00A5) begin n_err++; $display("FAIL lat%0d_data: got %h expected 00a5", l, got_q[0].data); end
    end
  endtask

  task automatic test_full();
    int acc;
    got_q.delete(); exp_q.delete();
    lat = 3'd1;
    rsp_bsy = 1'b1;
    acc = 0;
    mem_req = 1'b1; mem_read = 1'b1; mem_addr = 10'h005; mem_tag = 4'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_bsy === 1'b0) acc++;
      step();
      mem_tag = 4'(acc);
    end
    @(negedge clk);
    n_cmp++; if (acc != 4) begin n_err++; $display("FAIL full_accepts: got %0d expected 4", acc); end
    n_cmp++; if (mem_bsy !== 1'b1) begin n_err++; $display("FAIL full_bsy: got %b expected 1", mem_bsy); end
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL full_no_rsp: got %0d responses expected 0", got_q.size()); end
    step();
    rsp_bsy = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_bsy !== 1'b1) begin n_err++; $display("FAIL full_bsy_on_pop: got %b expected 1", mem_bsy); end
    step();
    @(negedge clk);
    n_cmp++; if (mem_bsy !== 1'b0) begin n_err++; $display("FAIL full_bsy_after_pop: got %b expected 0", mem_bsy); end
    step();
    mem_req = 1'b0;
    wait_rsp(5);
    n_cmp++; if (got_q.size() != 5) begin n_err++; $display("FAIL full_rsp_count: got %0d expected 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i].tag !== 4'(i) || got_q[i].data !== 16'h00A5)
        begin n_err++; $display("FAIL full_rsp%0d: got tag %0d data %h expected tag %0d data 00a5", i, got_q[i].tag, got_q[i].data, i); end
    end
  endtask

  task automatic test_overwrite();
    int t;
    got_q.delete(); exp_q.delete();
    lat = 3'd2;
    push(10'h3FF, 1'b0, 16'h1111, 4'd5, t);
    push(10'h3FF, 1'b0, 16'h2222, 4'd6, t);
    push(10'h3FF, 1'b1, 16'h0000, 4'd7, t);
    wait_rsp(1);
    n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL ovw_count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0].data !== 16'h2222 || got_q[0].tag !== 4'd7)
        begin n_err++; $display("FAIL ovw_data: got data %h tag %0d expected data 2222 tag 7", got_q[0].data, got_q[0].tag); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    got_q.delete(); exp_q.delete();
    lat = 3'd1;
    rsp_bsy = 1'b1;
    push(10'h3FF, 1'b1, 16'h0000, 4'd8, t);
    push(10'h3FF, 1'b1, 16'h0000, 4'd9, t);
    push(10'h3FF, 1'b1, 16'h0000, 4'd10, t);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    rsp_bsy = 1'b0;
    for (int k = 0; k < 10; k++) step();
    @(negedge clk);
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL rstmid_no_rsp: got %0d responses expected 0", got_q.size()); end
    n_cmp++; if (mem_bsy !== 1'b0) begin n_err++; $display("FAIL rstmid_bsy: got %b expected 0", mem_bsy); end
    n_cmp++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0)
      begin n_err++; $display("FAIL rstmid_cnt: got wr %0d rd %0d expected 0 0", wr_cnt, rd_cnt); end
    step();
    push(10'h3FF, 1'b1, 16'h0000, 4'd11, t);
    wait_rsp(1);
    n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL rstmid_rd_count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0].data !== 16'h2222) begin n_err++; $display("FAIL rstmid_retained: got %h expected 2222", got_q[0].data); end
    end
  endtask

  task automatic test_random();
    int          t, n_wr, n_rd;
    logic [15:0] base_wr, base_rd;
    logic        rd;
    got_q.delete(); exp_q.delete();
    @(negedge clk);
    base_wr = wr_cnt; base_rd = rd_cnt;
    n_wr = 0; n_rd = 0;
    step();
    bsy_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lat = 3'($urandom_range(0, 7));
      push(10'(i), 1'b0, 16'($urandom), 4'(i), t);
      n_wr++;
    end
    for (int i = 0; i < 48; i++) begin
      lat = 3'($urandom_range(0, 7));
      rd = 1'($urandom_range(0, 1));
      push(10'($urandom_range(0, 7)), rd, 16'($urandom), 4'(i), t);
      if (rd) n_rd++; else n_wr++;
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
    bsy_mode = 1'b0;
    rsp_bsy = 1'b0;
    wait_rsp(exp_q.size());
    @(negedge clk);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i].tag !== exp_q[i].tag || got_q[i].data !== exp_q[i].data)
        begin n_err++; $display("FAIL rnd_rsp%0d: got tag %0d data %h expected tag %0d data %h", i, got_q[i].tag, got_q[i].data, exp_q[i].tag, exp_q[i].data); end
    end
    n_cmp++; if (wr_cnt - base_wr !== 16'(n_wr)) begin n_err++; $display("FAIL rnd_wr_cnt: got %0d expected %0d", wr_cnt - base_wr, n_wr); end
    n_cmp++; if (rd_cnt - base_rd !== 16'(n_rd)) begin n_err++; $display("FAIL rnd_rd_cnt: got %0d expected %0d", rd_cnt - base_rd, n_rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency(3'd1, 2);
    test_latency(3'd4, 6);
    test_latency(3'd0, 2);
    test_full();
    test_overwrite();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_rsp_slave.md
Name: mem_rsp_slave

Overview:
- Memory-side responder for the round-robin arbiter's downstream request port.
- Accepts arbitrated requests (address, read/write, write data, tag) into an in-order request queue.
- Services each queued request against an internal W-bit x 2^AW storage array after a programmable latency.
- Returns read data with the original tag on a response port with downstream back-pressure, and asserts busy toward the arbiter when the queue is full.

Parameters:
- W, 16, data width of write data, read data and storage words
- AW, 10, address width; storage depth 2^AW
- TW, 4, tag width
- QAW, 2, request queue address width; queue depth QD = 2^QAW
- LATW, 3, width of the lat input

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lat  in  LATW  service latency in cycles; 0 is treated as 1; sampled when a request reaches the queue head
- mem_req  in  1  request valid from arbiter
- mem_addr  in  AW  request address
- mem_read  in  1  1 = read, 0 = write
- mem_wdata  in  W  write data (ignored for reads)
- mem_tag  in  TW  request tag
- mem_bsy  out  1  queue full; arbiter must hold its request
- rsp_vld  out  1  read response valid (one cycle per read)
- rsp_rdata  out  W  read data
- rsp_tag  out  TW  tag of the responded read
- rsp_bsy  in  1  downstream cannot take a response this cycle
- wr_cnt  out  16  writes committed, wraps at 16'hFFFF
- rd_cnt  out  16  reads responded, wraps at 16'hFFFF

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: clk and rst_n, and all state is cleared while rst_n=0.
- Reset values: mem_bsy=0, rsp_vld=0, rsp_rdata=0, rsp_tag=0, wr_cnt=0, rd_cnt=0; queue empty; FSM in IDLE. The storage array is not reset.
- Accept rule: a request is pushed when mem_req=1 and mem_bsy=0. The queue entry holds {addr, read, wdata, tag}.
- mem_bsy is combinational: mem_bsy = (count == QD).
  - A pop in the same cycle does not release mem_bsy; no push occurs while full.
  - Push and pop in the same cycle leave count unchanged.
- FSM:
  - IDLE: queue empty. When count becomes nonzero, go to WAIT and load timer = max(lat,1) - 1.
  - WAIT: decrement timer each cycle; when timer reaches 0, go to ISSUE. If the loaded value is 0, go directly to ISSUE.
  - ISSUE, head is a write: commit mem[addr] <= wdata and pop the head.
  - ISSUE, head is a read: when rsp_bsy=0, pop the head, and next cycle drive rsp_vld=1 with rsp_rdata=mem[addr] and rsp_tag=tag. When rsp_bsy=1, stay in ISSUE without popping.
  - After a pop: go to WAIT with a reload from lat if another entry remains (including one pushed that cycle); otherwise go to IDLE.
- Timing:
  - Minimum accept-to-response latency for a read at the head of an empty queue with lat=1 is 3 cycles: push, ISSUE, rsp_vld.
  - Back-to-back service with lat=1 is one pop every 2 cycles.
- Ordering:
  - Strictly in order. A read observes every earlier accepted write, including a write committed in the immediately preceding cycle.
- Outputs:
  - rsp_vld is a single-cycle pulse; rsp_rdata/rsp_tag hold their last value when rsp_vld=0.
  - wr_cnt increments on each write commit; rd_cnt increments on each rsp_vld.
- Reset mid-operation: the queue is flushed and pending requests are dropped with no response. Storage contents are retained.

Test Plan:
- lat=1: write addr 10'h005 data 16'h00A5 tag 1, then read addr 10'h005 tag 2 -> exactly one rsp_vld with rsp_rdata=16'h00A5, rsp_tag=2; wr_cnt=1, rd_cnt=1.
- lat=4: single read of addr 10'h005 at cycle T -> rsp_vld at T+6, and no earlier rsp_vld.
- Hold rsp_bsy=1 and lat=1, push 5 reads with mem_req held high -> mem_bsy=1 after 4 accepts; 5th request stalls; no rsp_vld. Release rsp_bsy -> 5 responses with tags in push order 0..4; mem_bsy drops after the first pop.
- Write 16'h1111, then 16'h2222 to addr 10'h3FF, then read addr 10'h3FF -> rsp_rdata=16'h2222.
- Assert rst_n=0 with 3 reads queued, then release -> no rsp_vld, counters=0, mem_bsy=0. A subsequent read of a previously written address returns the retained data.
- lat=0 behaves identically to lat=1: same response cycle for the same read stimulus.
